// File: rtl/d_phy_clk_lane_ctrl_if.sv
// Clock-lane bundle: CSI-side level requests, PPI status from the PHY, and the
// PPI controls/status flags produced by the clock lane sequencer.
interface d_phy_clk_lane_ctrl_if;
    logic       pwr_req;
    logic       hs_req;
    logic       idle_req;
    logic       ulps_req;
    logic       Stopstate;
    logic       TxReadyHS;
    logic       TxHSIdleClkReadyHS;
    logic       UlpsActiveNot;
    logic       Enable;
    logic       TxRequestHS;
    logic       TxHSIdleClkHS;
    logic       TxUlpsClk;
    logic       TxUlpsExit;
    logic       clk_hs_ok;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    // master: CSI controller + PHY side; slave: the sequencer
    modport master (
        output pwr_req, hs_req, idle_req, ulps_req,
               Stopstate, TxReadyHS, TxHSIdleClkReadyHS, UlpsActiveNot,
        input  Enable, TxRequestHS, TxHSIdleClkHS, TxUlpsClk, TxUlpsExit,
               clk_hs_ok, busy, err, err_code
    );
    modport slave (
        input  pwr_req, hs_req, idle_req, ulps_req,
               Stopstate, TxReadyHS, TxHSIdleClkReadyHS, UlpsActiveNot,
        output Enable, TxRequestHS, TxHSIdleClkHS, TxUlpsClk, TxUlpsExit,
               clk_hs_ok, busy, err, err_code
    );
endinterface

// File: rtl/d_phy_clk_lane_ctrl.sv
// D-PHY master clock lane PPI sequencer: turns CSI level requests into legal
// HS / HS-idle / ULPS control sequences and flags time-outs and illegal events.
module d_phy_clk_lane_ctrl #(
    parameter int TIMEOUT_CYC  = 4096,
    parameter int MIN_STOP_CYC = 8,
    parameter int MIN_IDLE_CYC = 4,
    parameter int CNT_W        = 13
) (
    input logic                   TxWordClkHS,
    input logic                   rst,
    d_phy_clk_lane_ctrl_if.slave  lane
);

    typedef enum logic [3:0] {
        S_OFF, S_INIT, S_STOP, S_HS_REQ, S_HS_ACT, S_HS_EXIT, S_IDL_REQ, S_IDLE,
        S_IDL_EXIT, S_ULPS_IN, S_ULPS, S_ULPS_OUT, S_ULPS_END, S_ERR
    } state_e;

    typedef enum logic [1:0] {E_NONE, E_TIMEOUT, E_ILLEGAL, E_GLITCH} err_e;

    typedef struct packed {
        logic enable;
        logic tx_request_hs;
        logic tx_hs_idle_clk_hs;
        logic tx_ulps_clk;
        logic tx_ulps_exit;
        logic clk_hs_ok;
        logic busy;
    } ctrl_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] STOP_GAP  = CNT_W'(MIN_STOP_CYC);
    localparam logic [CNT_W-1:0] IDLE_HOLD = CNT_W'(MIN_IDLE_CYC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    err_e             err_code_q, err_code_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             waiting, illegal, glitch;

    function automatic ctrl_t decode(input state_e s);
        ctrl_t c;
        c                   = '0;
        c.enable            = (s != S_OFF);
        c.tx_request_hs     = s inside {S_HS_REQ, S_HS_ACT, S_IDL_REQ, S_IDLE, S_IDL_EXIT};
        c.tx_hs_idle_clk_hs = s inside {S_IDL_REQ, S_IDLE};
        c.tx_ulps_clk       = s inside {S_ULPS_IN, S_ULPS, S_ULPS_OUT};
        c.tx_ulps_exit      = (s == S_ULPS_OUT);
        c.clk_hs_ok         = (s == S_HS_ACT);
        c.busy              = !(s inside {S_OFF, S_STOP});
        return c;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        waiting    = state_q inside {S_INIT, S_HS_REQ, S_HS_EXIT, S_IDL_REQ, S_IDL_EXIT,
                                     S_ULPS_IN, S_ULPS_OUT, S_ULPS_END};
        illegal    = (lane.ulps_req &&
                      (state_q inside {S_HS_REQ, S_HS_ACT, S_IDL_REQ, S_IDLE, S_IDL_EXIT})) ||
                     (state_q == S_IDLE && !lane.hs_req);
        glitch     = (state_q == S_HS_ACT && lane.Stopstate) ||
                     (state_q == S_ULPS && lane.UlpsActiveNot);

        if (!lane.pwr_req) begin
            state_d    = S_OFF;
            err_d      = 1'b0;
            err_code_d = E_NONE;
        end else if (state_q == S_ERR) begin
            state_d = S_ERR;
        end else if (waiting && cnt_q == CNT_MAX) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = E_TIMEOUT;
        end else if (illegal) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = E_ILLEGAL;
        end else if (glitch) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = E_GLITCH;
        end else begin
            unique case (state_q)
                S_OFF:      state_d = S_INIT;
                S_INIT:     if (lane.Stopstate) state_d = S_STOP;
                // requests raised during the post-HS gap simply wait for it to expire
                S_STOP:     if (cnt_q >= STOP_GAP) begin
                                if (lane.hs_req)        state_d = S_HS_REQ;
                                else if (lane.ulps_req) state_d = S_ULPS_IN;
                            end
                S_HS_REQ:   if (lane.TxReadyHS) state_d = S_HS_ACT;
                S_HS_ACT:   if (!lane.hs_req)       state_d = S_HS_EXIT;
                            else if (lane.idle_req) state_d = S_IDL_REQ;
                S_HS_EXIT:  if (!lane.TxReadyHS && lane.Stopstate) state_d = S_STOP;
                S_IDL_REQ:  if (lane.TxHSIdleClkReadyHS) state_d = S_IDLE;
                S_IDLE:     if (!lane.idle_req && cnt_q >= IDLE_HOLD) state_d = S_IDL_EXIT;
                S_IDL_EXIT: if (!lane.TxHSIdleClkReadyHS && lane.TxReadyHS) state_d = S_HS_ACT;
                S_ULPS_IN:  if (!lane.UlpsActiveNot) state_d = S_ULPS;
                S_ULPS:     if (!lane.ulps_req) state_d = S_ULPS_OUT;
                S_ULPS_OUT: if (lane.UlpsActiveNot) state_d = S_ULPS_END;
                S_ULPS_END: if (lane.Stopstate) state_d = S_STOP;
                default:    state_d = S_ERR;
            endcase
        end

        if (state_d != state_q)   cnt_d = '0;
        else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
        else                       cnt_d = cnt_q + CNT_W'(1);

        // Controls follow the next state so each output lands one cycle after its cause.
        ctrl_d = decode(state_d);
    end

    // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge TxWordClkHS or posedge rst) begin
        if (rst) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= E_NONE;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign lane.Enable        = ctrl_q.enable;
    assign lane.TxRequestHS   = ctrl_q.tx_request_hs;
    assign lane.TxHSIdleClkHS = ctrl_q.tx_hs_idle_clk_hs;
    assign lane.TxUlpsClk     = ctrl_q.tx_ulps_clk;
    assign lane.TxUlpsExit    = ctrl_q.tx_ulps_exit;
    assign lane.clk_hs_ok     = ctrl_q.clk_hs_ok;
    assign lane.busy          = ctrl_q.busy;
    assign lane.err           = err_q;
    assign lane.err_code      = err_code_q;

endmodule

// File: tb/tb_d_phy_clk_lane_ctrl.sv
// Directed bench for d_phy_clk_lane_ctrl: expected output vectors are queued as
// stimulus is applied and popped/compared one cycle later.
module tb_d_phy_clk_lane_ctrl;

    localparam int TIMEOUT_CYC = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    d_phy_clk_lane_ctrl_if lane ();

    d_phy_clk_lane_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MIN_STOP_CYC(8),
        .MIN_IDLE_CYC(4),
        .CNT_W       (13)
    ) dut (
        .TxWordClkHS(clk),
        .rst        (rst),
        .lane       (lane)
    );

    // {Enable, TxRequestHS, TxHSIdleClkHS, TxUlpsClk, TxUlpsExit, clk_hs_ok, busy, err, err_code}
    typedef logic [9:0] obs_t;
    localparam obs_t B_EN = 10'h200, B_REQ = 10'h100, B_IDL = 10'h080, B_ULPS = 10'h040;
    localparam obs_t B_EXIT = 10'h020, B_OK = 10'h010, B_BUSY = 10'h008, B_ERR = 10'h004;

    localparam obs_t O_OFF     = 10'h000;
    localparam obs_t O_INIT    = B_EN | B_BUSY;
    localparam obs_t O_STOP    = B_EN;
    localparam obs_t O_HSREQ   = B_EN | B_REQ | B_BUSY;
    localparam obs_t O_HSACT   = B_EN | B_REQ | B_OK | B_BUSY;
    localparam obs_t O_HSEXIT  = B_EN | B_BUSY;
    localparam obs_t O_IDLE    = B_EN | B_REQ | B_IDL | B_BUSY;
    localparam obs_t O_IDLEXIT = B_EN | B_REQ | B_BUSY;
    localparam obs_t O_ULPS    = B_EN | B_ULPS | B_BUSY;
    localparam obs_t O_ULPSOUT = B_EN | B_ULPS | B_EXIT | B_BUSY;
    localparam obs_t O_ULPSEND = B_EN | B_BUSY;
    localparam obs_t O_ERR1    = B_EN | B_BUSY | B_ERR | 10'd1;
    localparam obs_t O_ERR2    = B_EN | B_BUSY | B_ERR | 10'd2;
    localparam obs_t O_ERR3    = B_EN | B_BUSY | B_ERR | 10'd3;

    int    tests = 0;
    int    fails = 0;
    string tag_q[$];
    obs_t  exp_q[$];

    function automatic obs_t observe();
        return {lane.Enable, lane.TxRequestHS, lane.TxHSIdleClkHS, lane.TxUlpsClk,
                lane.TxUlpsExit, lane.clk_hs_ok, lane.busy, lane.err, lane.err_code};
    endfunction

    task automatic check(input obs_t obs);
        string t;
        obs_t  e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    // Queue n expectations, one per clock, and compare each #1 after its edge.
    task automatic cyc(input string tag, input obs_t e, input int n = 1);
        for (int i = 0; i < n; i++) begin
            tag_q.push_back(tag);
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            check(observe());
        end
    endtask

    initial begin
        int waited;
        rst                     = 1'b1;
        lane.pwr_req            = 1'b0;
        lane.hs_req             = 1'b0;
        lane.idle_req           = 1'b0;
        lane.ulps_req           = 1'b0;
        lane.Stopstate          = 1'b0;
        lane.TxReadyHS          = 1'b0;
        lane.TxHSIdleClkReadyHS = 1'b0;
        lane.UlpsActiveNot      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tag_q.push_back("reset");
        exp_q.push_back(O_OFF);
        check(observe());
        rst = 1'b0;

        // power up, Stopstate arrives late
        lane.pwr_req = 1'b1;
        cyc("init_enable", O_INIT, 4);
        lane.Stopstate = 1'b1;
        cyc("stop_reached", O_STOP);

        // HS request waits out the stop gap, then TxReadyHS after 10 cycles
        lane.hs_req = 1'b1;
        cyc("stop_gap", O_STOP, 8);
        cyc("hs_req", O_HSREQ);
        lane.Stopstate = 1'b0;
        cyc("wait_ready", O_HSREQ, 9);
        lane.TxReadyHS = 1'b1;
        cyc("hs_act", O_HSACT, 3);

        // one-cycle idle_req pulse, idle clock held for the minimum time
        lane.idle_req = 1'b1;
        cyc("idl_req", O_IDLE);
        lane.idle_req = 1'b0;
        cyc("idl_req_wait", O_IDLE, 2);
        lane.TxHSIdleClkReadyHS = 1'b1;
        cyc("idle_hold", O_IDLE, 5);
        cyc("idl_exit", O_IDLEXIT);
        lane.TxHSIdleClkReadyHS = 1'b0;
        cyc("idle_back_hs_act", O_HSACT);

        // HS exit, re-request 2 cycles into STOP: held until the gap expires
        lane.hs_req = 1'b0;
        cyc("hs_exit", O_HSEXIT);
        lane.TxReadyHS = 1'b0;
        lane.Stopstate = 1'b1;
        cyc("stop_after_hs", O_STOP, 2);
        lane.hs_req = 1'b1;
        cyc("rereq_pending", O_STOP, 7);
        cyc("rereq_hs_req", O_HSREQ);
        lane.Stopstate = 1'b0;
        lane.TxReadyHS = 1'b1;
        cyc("hs_act2", O_HSACT);

        // ULPS round trip
        lane.hs_req = 1'b0;
        cyc("hs_exit2", O_HSEXIT);
        lane.TxReadyHS = 1'b0;
        lane.Stopstate = 1'b1;
        cyc("stop_before_ulps", O_STOP);
        lane.ulps_req = 1'b1;
        cyc("ulps_pending", O_STOP, 8);
        cyc("ulps_in", O_ULPS, 3);
        lane.UlpsActiveNot = 1'b0;
        lane.Stopstate     = 1'b0;
        cyc("ulps_active", O_ULPS, 2);
        lane.ulps_req = 1'b0;
        cyc("ulps_exit", O_ULPSOUT, 3);
        lane.UlpsActiveNot = 1'b1;
        cyc("ulps_end", O_ULPSEND, 2);
        lane.Stopstate = 1'b1;
        cyc("ulps_stop", O_STOP);

        // hs_req and ulps_req together: HS wins; then a Stopstate glitch in HS_ACT
        lane.hs_req   = 1'b1;
        lane.ulps_req = 1'b1;
        cyc("tie_pending", O_STOP, 8);
        cyc("tie_hs_wins", O_HSREQ);
        lane.ulps_req  = 1'b0;
        lane.Stopstate = 1'b0;
        lane.TxReadyHS = 1'b1;
        cyc("hs_act3", O_HSACT);
        lane.Stopstate = 1'b1;
        cyc("glitch_err", O_ERR3);
        lane.Stopstate = 1'b0;
        cyc("err_sticky", O_ERR3, 2);

        // abort clears the error; then ulps_req while in HS_REQ is illegal
        lane.pwr_req   = 1'b0;
        lane.TxReadyHS = 1'b0;
        cyc("abort_glitch", O_OFF);
        lane.pwr_req   = 1'b1;
        lane.Stopstate = 1'b1;
        cyc("repower_init", O_INIT);
        cyc("repower_stop", O_STOP, 9);
        cyc("repower_hs_req", O_HSREQ);
        lane.ulps_req = 1'b1;
        cyc("illegal_ulps", O_ERR2);
        lane.ulps_req = 1'b0;
        lane.pwr_req  = 1'b0;
        cyc("abort_illegal", O_OFF);

        // TxReadyHS never rises: timeout
        lane.pwr_req = 1'b1;
        cyc("to_init", O_INIT);
        cyc("to_stop", O_STOP, 9);
        cyc("to_hs_req", O_HSREQ);
        waited = 0;
        while (!lane.err && waited < TIMEOUT_CYC + 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        tests++;
        assert (waited === TIMEOUT_CYC + 1) else begin
            fails++;
            $error("FAIL timeout_latency: observed %0d expected %0d", waited, TIMEOUT_CYC + 1);
        end
        tag_q.push_back("timeout_err");
        exp_q.push_back(O_ERR1);
        check(observe());
        lane.pwr_req = 1'b0;
        lane.hs_req  = 1'b0;
        cyc("abort_timeout", O_OFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
